// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants for the instruction fetch unit: FSM state
//                encodings and the PC increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t IDLE  = 2'd0;
    localparam fetch_state_t RUN   = 2'd1;
    localparam fetch_state_t FLUSH = 2'd2;

    localparam int unsigned PC_INC = 2;

    // A prefetch queue entry is packed as {pc, instr}, pc = fetch address + PC_INC.

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_unit_if
//  Description : Instruction memory request/response bus. master = fetch unit,
//                slave = instruction memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if #(
    parameter int WIDTH = 16
);
    logic             req;
    logic [WIDTH-1:0] addr;
    logic             gnt;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface : instruction_fetch_unit_if
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Synchronous FIFO with push/pop/clear, occupancy count and
//                full/empty flags. Push on full is accepted only with a pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      push_data,
    output logic [DATA_W-1:0]      head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule : fetch_queue
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_unit
//  Description : IF stage - fetch PC, single-outstanding imem requests, prefetch
//                queue feeding IF/ID, redirect flush. Optional FETCH_PERF_CNT_EN
//                adds a saturating BUBBLE_COUNT register.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               FIFO_DEPTH = 2,
    parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [WIDTH-1:0]         redirect_pc,
    instruction_fetch_unit_if.master imem,
    output logic [WIDTH-1:0]         program_counter,
    output logic [WIDTH-1:0]         instruction,
    output logic                     write_enable
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]              bubble_count
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(FIFO_DEPTH);
    localparam logic [WIDTH-1:0] c_pc_step = WIDTH'(PC_INC);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [WIDTH-1:0]   r_fetch_pc;
    logic [WIDTH-1:0]   r_req_addr;
    logic               r_outstanding;

    logic               w_rsp;
    logic               w_push;
    logic               w_pop;
    logic               w_req;
    logic               w_fire;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_count_next;
    logic               w_full;
    logic               w_empty;
    logic [2*WIDTH-1:0] w_head;
    logic [WIDTH-1:0]   w_redirect_target;

    // A response is only meaningful against a tracked request.
    assign w_rsp  = imem.rvalid & r_outstanding;
    assign w_push = w_rsp & (r_state == RUN) & ~redirect;
    assign w_pop  = write_enable;

    assign write_enable = ~w_empty & ~stall & ~redirect;

    // A new request needs a free slot once this cycle's push/pop settle; the
    // returning response frees the outstanding slot, giving 1 instr/cycle.
    assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_req  = (r_state == RUN) & ~redirect
                  & (~r_outstanding | w_rsp)
                  & (w_count_next < c_depth);
    assign w_fire = w_req & imem.gnt;

    assign imem.req  = w_req;
    assign imem.addr = w_req ? r_fetch_pc : '0;

    assign w_redirect_target = redirect_pc & ~WIDTH'(1);

    always_comb begin
        w_state_next = r_state;
        if (redirect) begin
            w_state_next = (r_outstanding & ~imem.rvalid) ? FLUSH : RUN;
        end else begin
            case (r_state)
                IDLE:    w_state_next = RUN;
                RUN:     w_state_next = RUN;
                FLUSH:   w_state_next = w_rsp ? RUN : FLUSH;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_fetch_pc    <= RESET_PC;
            r_req_addr    <= '0;
            r_outstanding <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_fire) begin
                r_outstanding <= 1'b1;
                r_req_addr    <= r_fetch_pc;
            end else if (w_rsp) begin
                r_outstanding <= 1'b0;
            end
            if (redirect)    r_fetch_pc <= w_redirect_target;
            else if (w_fire) r_fetch_pc <= r_fetch_pc + c_pc_step;
        end
    end

    fetch_queue #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect),
        .push      (w_push),
        .pop       (w_pop),
        .push_data ({r_req_addr + c_pc_step, imem.rdata}),
        .head_data (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign program_counter = w_empty ? '0 : w_head[2*WIDTH-1:WIDTH];
    assign instruction     = w_empty ? '0 : w_head[WIDTH-1:0];

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_bubble_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_count <= '0;
        end else if ((r_state == RUN || r_state == FLUSH) && !stall && w_empty
                     && r_bubble_count != 16'hFFFF) begin
            r_bubble_count <= r_bubble_count + 16'd1;
        end
    end

    assign bubble_count = r_bubble_count;
`endif

    a_rvalid_needs_request: assert property (
        @(posedge clk) disable iff (!rst_n) imem.rvalid |-> r_outstanding
    ) else $error("imem rvalid arrived with no request outstanding");

    a_queue_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n) w_push |-> (!w_full || w_pop)
    ) else $error("prefetch queue push while full");

endmodule : instruction_fetch_unit
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_unit
//  Description : Random imem timing/stall/redirect stimulus; expected pair stream
//                kept in a queue, popped by an independent output monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;
    localparam int          WIDTH    = 16;
    localparam int          DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [15:0] program_counter;
    logic [15:0] instruction;
    logic        write_enable;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] bubble_count;
`endif

    instruction_fetch_unit_if #(.WIDTH(WIDTH)) imem_bus ();

    instruction_fetch_unit #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem            (imem_bus),
        .program_counter (program_counter),
        .instruction     (instruction),
        .write_enable    (write_enable)
`ifdef FETCH_PERF_CNT_EN
        ,
        .bubble_count    (bubble_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Program image: a bijective scramble of the address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[6:0], a[15:7]} ^ 16'h5AC3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected {pc+2, instr} pairs in program order.
    logic [31:0] exp_q[$];
    logic [15:0] stream_next;

    task automatic push_stream(input logic [15:0] start, input int n);
        logic [15:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({a + 16'd2, mem_word(a)});
            a = a + 16'd2;
        end
        stream_next = a;
    endtask

    // Memory model / driver state
    bit          pend = 0;
    logic [15:0] pend_addr = '0;
    int          pend_cnt = 0;
    bit          pend_stale = 0;
    bit          rsp_stale_now = 0;
    int          gnt_delay = 0;
    int          lat = 1;
    int          wait_cnt = 0;
    bit          prev_wait = 0;
    logic [15:0] prev_addr = '0;
    bit          chk_addr_en = 0;
    logic [15:0] chk_addr = '0;
    bit          last_req = 0;
    bit          last_we = 0;
    bit          wrap_seen = 0;

    task automatic drive_cycle(input bit st, input bit rd, input logic [15:0] rpc);
        bit g;
        @(negedge clk);
        rsp_stale_now = 0;
        if (pend && pend_cnt <= 1) begin
            imem_bus.rvalid = 1'b1;
            imem_bus.rdata  = mem_word(pend_addr);
            rsp_stale_now   = pend_stale;
            pend            = 0;
        end else begin
            imem_bus.rvalid = 1'b0;
            imem_bus.rdata  = 16'($urandom);
            if (pend) pend_cnt--;
        end
        stall = st;
        redirect = rd;
        redirect_pc = rpc;
        #1;
        if (prev_wait && !rd) begin
            check("req_hold", {31'd0, imem_bus.req}, 32'd1);
            check("addr_hold", {16'd0, imem_bus.addr}, {16'd0, prev_addr});
        end
        if (imem_bus.req) begin
            check("one_outstanding", {31'd0, pend}, 32'd0);
            g = (wait_cnt >= gnt_delay);
            if (!g) wait_cnt++;
        end else begin
            g = 0;
            wait_cnt = 0;
        end
        imem_bus.gnt = g;
        prev_wait = imem_bus.req && !g;
        prev_addr = imem_bus.addr;
        if (imem_bus.req && g) begin
            if (chk_addr_en) begin
                check("addr_after_redirect", {16'd0, imem_bus.addr}, {16'd0, chk_addr});
                chk_addr_en = 0;
            end
            pend = 1;
            pend_addr = imem_bus.addr;
            pend_cnt = lat;
            pend_stale = 0;
            wait_cnt = 0;
        end
        last_req = imem_bus.req;
        last_we  = write_enable;
        if (rd) begin
            if (pend) pend_stale = 1;
            exp_q.delete();
            push_stream(rpc & 16'hFFFE, 64);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req", {31'd0, imem_bus.req}, 32'd0);
        check("rst_addr", {16'd0, imem_bus.addr}, 32'd0);
        check("rst_we", {31'd0, write_enable}, 32'd0);
        check("rst_pc", {16'd0, program_counter}, 32'd0);
        check("rst_instr", {16'd0, instruction}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_bubble", {16'd0, bubble_count}, 32'd0);
`endif
        pend = 0; prev_wait = 0; wait_cnt = 0; chk_addr_en = 0;
        imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = '0;
        stall = 1'b0; redirect = 1'b0;
        exp_q.delete();
        push_stream(RESET_PC, 64);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Output monitor: independent occupancy model plus scoreboard pops.
    int          occ = 0;
    int          since_rel = 0;
    logic [15:0] perf_exp = '0;

    initial begin
        logic [31:0] e;
        bit          exp_we;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                occ = 0;
                since_rel = 0;
                perf_exp = '0;
            end else begin
                exp_we = (occ != 0) && !stall && !redirect;
                check("write_enable", {31'd0, write_enable}, {31'd0, exp_we});
                if (occ == 0) begin
                    check("empty_pc", {16'd0, program_counter}, 32'd0);
                    check("empty_instr", {16'd0, instruction}, 32'd0);
                end
                if (write_enable) begin
                    if (exp_q.size() < 4) push_stream(stream_next, 64);
                    e = exp_q.pop_front();
                    check("pair_pc", {16'd0, program_counter}, {16'd0, e[31:16]});
                    check("pair_instr", {16'd0, instruction}, {16'd0, e[15:0]});
                    if (program_counter == 16'h0000 && instruction == mem_word(16'hFFFE))
                        wrap_seen = 1;
                end
`ifdef FETCH_PERF_CNT_EN
                check("bubble_count", {16'd0, bubble_count}, {16'd0, perf_exp});
                if (since_rel >= 1 && !stall && occ == 0 && perf_exp != 16'hFFFF)
                    perf_exp = perf_exp + 16'd1;
`endif
                if (redirect) occ = 0;
                else occ = occ + ((imem_bus.rvalid && !rsp_stale_now) ? 1 : 0) - (exp_we ? 1 : 0);
                if (since_rel < 1000) since_rel++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        imem_bus.gnt = 1'b0;
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata = '0;
        push_stream(RESET_PC, 64);
        #3;
        check("rst_req", {31'd0, imem_bus.req}, 32'd0);
        check("rst_addr", {16'd0, imem_bus.addr}, 32'd0);
        check("rst_we", {31'd0, write_enable}, 32'd0);
        check("rst_pc", {16'd0, program_counter}, 32'd0);
        check("rst_instr", {16'd0, instruction}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait memory: one pair per cycle once the pipe fills.
        gnt_delay = 0; lat = 1;
        n = 0;
        while (!last_we && n < 20) begin drive_cycle(0, 0, '0); n++; end
        check("first_we_seen", {31'd0, last_we}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(0, 0, '0);
            check("back_to_back_we", {31'd0, last_we}, 32'd1);
        end

        // Four stall cycles fill the queue and stop requests; head is held.
        for (int i = 0; i < 4; i++) drive_cycle(1, 0, '0);
        check("stall_req_drop", {31'd0, last_req}, 32'd0);
        check("stall_head_pc", {16'd0, program_counter}, {16'd0, exp_q[0][31:16]});
        repeat (8) drive_cycle(0, 0, '0);

        // Slow grant.
        gnt_delay = 3;
        repeat (20) drive_cycle(0, 0, '0);

        // Redirect to an odd target while a request is in flight.
        gnt_delay = 0; lat = 3;
        n = 0;
        while (!(pend && pend_cnt >= 2) && n < 20) begin drive_cycle(0, 0, '0); n++; end
        check("outstanding_before_redirect", {31'd0, pend}, 32'd1);
        chk_addr = 16'h0040; chk_addr_en = 1;
        drive_cycle(0, 1, 16'h0041);
        repeat (20) drive_cycle(0, 0, '0);
        check("redirect_grant_seen", {31'd0, chk_addr_en}, 32'd0);

        // PC wrap-around.
        lat = 1;
        drive_cycle(0, 1, 16'hFFFC);
        repeat (15) drive_cycle(0, 0, '0);
        check("wrap_pair_seen", {31'd0, wrap_seen}, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            gnt_delay = $urandom_range(0, 3);
            lat = $urandom_range(1, 3);
            drive_cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
                        16'($urandom));
            if (i == 700) apply_reset();
        end

        // Drain.
        lat = 1; gnt_delay = 0;
        repeat (10) drive_cycle(0, 0, '0);
        @(negedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instruction_fetch_unit
`default_nettype wire
